// File: rtl/bnb_pkg.sv
// bnb_pkg: shared defaults and types for the block_nonblock coding-style reference.
//   BNB_WIDTH_DEF : default data width
//   BNB_DEPTH_DEF : default number of stages in the non-blocking shift chain
//   bnb_stage_t   : one shift stage at the default width
package bnb_pkg;

    localparam int unsigned BNB_WIDTH_DEF = 1;
    localparam int unsigned BNB_DEPTH_DEF = 2;

    typedef logic [BNB_WIDTH_DEF-1:0] bnb_stage_t;

endpackage

// File: rtl/bnb_dff.sv
// bnb_dff: WIDTH-bit D flip-flop with asynchronous active-low clear.
// Ports:
//   clk_i   rising-edge clock
//   rst_ni  asynchronous active-low clear; q_o is forced to 0 while low
//   d_i     data input
//   q_o     registered output
module bnb_dff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= '0;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/block_nonblock.sv
// block_nonblock: side-by-side view of the two structures a two-statement sequential
// chain can infer.
//   q_block    : chain collapsed to a single register (blocking semantics), latency 1
//   q_nonblock : true DEPTH-stage shift register (non-blocking semantics), latency DEPTH
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset, clears every stage
//   d           serial data input
//   q_block     d delayed by 1 cycle
//   q_nonblock  d delayed by DEPTH cycles
//   taps        {stage[DEPTH-1], ..., stage[0]} (present only when BNB_TAPS_EN is defined)
// Configuration macro: BNB_TAPS_EN
module block_nonblock
    import bnb_pkg::*;
#(
    parameter int unsigned WIDTH = BNB_WIDTH_DEF,
    parameter int unsigned DEPTH = BNB_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       d,
    output logic [WIDTH-1:0]       q_block,
`ifdef BNB_TAPS_EN
    output logic [WIDTH*DEPTH-1:0] taps,
`endif
    output logic [WIDTH-1:0]       q_nonblock
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Blocking form: the intermediate variable vanishes, leaving one flop.
    bnb_dff #(
        .WIDTH (WIDTH)
    ) u_block_dff (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .d_i    (d),
        .q_o    (q_block)
    );

    // Non-blocking form: every statement keeps its own flop.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            bnb_dff #(
                .WIDTH (WIDTH)
            ) u_dff (
                .clk_i  (clk),
                .rst_ni (rst_n),
                .d_i    (d),
                .q_o    (stage[i])
            );
        end else begin : g_body
            bnb_dff #(
                .WIDTH (WIDTH)
            ) u_dff (
                .clk_i  (clk),
                .rst_ni (rst_n),
                .d_i    (stage[i-1]),
                .q_o    (stage[i])
            );
        end
    end

    assign q_nonblock = stage[DEPTH-1];

`ifdef BNB_TAPS_EN
    always_comb begin
        taps = '0;
        for (int i = 0; i < DEPTH; i++) begin
            taps[i*WIDTH +: WIDTH] = stage[i];
        end
    end
`endif

endmodule

// File: tb/tb_block_nonblock.sv
// tb_block_nonblock: self-checking bench for block_nonblock.
// Three instances: A (WIDTH=1, DEPTH=2), B (WIDTH=8, DEPTH=4), C (WIDTH=1, DEPTH=4, taps).
// The reference model keeps, per instance, the history of values sampled since the last
// reset; an output delayed by k cycles must equal the k-th most recent sample, or 0 when
// fewer than k samples have been taken since reset.
module tb_block_nonblock;

    logic       clk;
    logic       rst_n;
    logic       d_a;
    logic [7:0] d_b;
    logic       d_c;
    logic       qb_a, qn_a;
    logic [7:0] qb_b, qn_b;
    logic       qb_c, qn_c;
`ifdef BNB_TAPS_EN
    logic [1:0] taps_a;
    logic [31:0] taps_b;
    logic [3:0] taps_c;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Most recent sample at index 0.
    logic       hq_a[$];
    logic [7:0] hq_b[$];
    logic       hq_c[$];

    block_nonblock #(.WIDTH(1), .DEPTH(2)) u_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d_a),
        .q_block    (qb_a),
`ifdef BNB_TAPS_EN
        .taps       (taps_a),
`endif
        .q_nonblock (qn_a)
    );

    block_nonblock #(.WIDTH(8), .DEPTH(4)) u_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d_b),
        .q_block    (qb_b),
`ifdef BNB_TAPS_EN
        .taps       (taps_b),
`endif
        .q_nonblock (qn_b)
    );

    block_nonblock #(.WIDTH(1), .DEPTH(4)) u_c (
        .clk        (clk),
        .rst_n      (rst_n),
        .d          (d_c),
        .q_block    (qb_c),
`ifdef BNB_TAPS_EN
        .taps       (taps_c),
`endif
        .q_nonblock (qn_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic dly_a(int unsigned k);
        if (hq_a.size() >= k) return hq_a[k-1];
        return 1'b0;
    endfunction

    function automatic logic [7:0] dly_b(int unsigned k);
        if (hq_b.size() >= k) return hq_b[k-1];
        return 8'h00;
    endfunction

    function automatic logic dly_c(int unsigned k);
        if (hq_c.size() >= k) return hq_c[k-1];
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] exp_taps;
        check({tag, "_qb_a"}, {31'd0, qb_a}, {31'd0, dly_a(1)});
        check({tag, "_qn_a"}, {31'd0, qn_a}, {31'd0, dly_a(2)});
        check({tag, "_qb_b"}, {24'd0, qb_b}, {24'd0, dly_b(1)});
        check({tag, "_qn_b"}, {24'd0, qn_b}, {24'd0, dly_b(4)});
        check({tag, "_qb_c"}, {31'd0, qb_c}, {31'd0, dly_c(1)});
        check({tag, "_qn_c"}, {31'd0, qn_c}, {31'd0, dly_c(4)});
`ifdef BNB_TAPS_EN
        for (int i = 0; i < 4; i++) exp_taps[i] = dly_c(i + 1);
        check({tag, "_taps_c"}, {28'd0, taps_c}, {28'd0, exp_taps});
        check({tag, "_taps_a"}, {30'd0, taps_a}, {30'd0, dly_a(2), dly_a(1)});
`else
        exp_taps = 4'd0;
`endif
    endtask

    task automatic clear_model();
        hq_a.delete();
        hq_b.delete();
        hq_c.delete();
    endtask

    // Drive inputs on the falling edge, let one rising edge happen, check 1 time unit later.
    task automatic step(input string tag, input logic r, input logic a, input logic [7:0] b,
                        input logic c);
        @(negedge clk);
        rst_n = r;
        d_a   = a;
        d_b   = b;
        d_c   = c;
        if (!r) clear_model();
        @(posedge clk);
        if (rst_n) begin
            hq_a.push_front(d_a);
            hq_b.push_front(d_b);
            hq_c.push_front(d_c);
            if (hq_a.size() > 8) void'(hq_a.pop_back());
            if (hq_b.size() > 8) void'(hq_b.pop_back());
            if (hq_c.size() > 8) void'(hq_c.pop_back());
        end
        #1;
        check_all(tag);
    endtask

    // Assert reset in the middle of the low clock phase and check before the next edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_all(tag);
    endtask

    logic [2:0] t3_pat [10];

    initial begin
        rst_n = 1'b1;
        d_a   = 1'b0;
        d_b   = 8'h00;
        d_c   = 1'b0;
        #3;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_all("reset_async");

        // T1: reset held with d=1, then release.
        for (int i = 0; i < 3; i++) step("t1_hold", 1'b0, 1'b1, 8'hFF, 1'b1);
        step("t1_release", 1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) step("t1_flush", 1'b1, 1'b0, 8'h00, 1'b0);

        // T2 / T5 / T6: single pulse on every instance.
        step("t2_pulse", 1'b1, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) step("t2_after", 1'b1, 1'b0, 8'h00, 1'b0);

        // T3: fixed pattern on A and C, shifted bytes on B.
        begin
            logic [9:0] pat;
            pat = 10'b0011101100;
            for (int i = 0; i < 10; i++)
                step("t3_pat", 1'b1, pat[i], {4'h0, 3'd0, pat[i]} << (i % 8), pat[i]);
        end

        // T4: fill with 1s, reset between edges, then refill.
        for (int i = 0; i < 5; i++) step("t4_fill", 1'b1, 1'b1, 8'hFF, 1'b1);
        async_reset("t4_async");
        step("t4_held", 1'b0, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 5; i++) step("t4_refill", 1'b1, 1'b1, 8'hFF, 1'b1);

        // Unknown input travels through with the same latency.
        step("x_in", 1'b1, 1'bx, 8'h3C, 1'b0);
        for (int i = 0; i < 4; i++) step("x_after", 1'b1, 1'b0, 8'h00, 1'b0);

        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                async_reset("rnd_async");
            end
            step("rnd", ($urandom_range(0, 9) != 0), 1'($urandom), 8'($urandom),
                 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
